// File: rtl/mssd_tx_pkg.sv
// mssd_tx_pkg -- shared types and constants for the MSSD serial transmit scheduler.
// Used by mssd_tx_arbiter and mssd_tx_scheduler.
package mssd_tx_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PN_W      = 2;
    localparam int LEN_W     = 6;
    localparam int HDR_BITS  = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Index of the last bit in an 8-bit slot (header or payload byte).
    localparam logic [2:0] LAST_BIT = 3'(HDR_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        HEADER,
        DATA,
        STOP
    } state_t;

    typedef logic [PN_W-1:0]  pn_t;
    typedef logic [LEN_W-1:0] len_t;

    // Encode a one-hot port vector into its port number (0 when empty).
    function automatic pn_t onehot_to_pn(input logic [NUM_PORTS-1:0] oh);
        pn_t pn;
        pn = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) pn = pn_t'(i);
        end
        return pn;
    endfunction

endpackage

// File: rtl/mssd_tx_arbiter.sv
// mssd_tx_arbiter -- picks one requesting port and returns it one-hot.
// Macro MSSD_TX_RR_EN: defined -> round-robin search starting at ptr;
// undefined -> fixed priority, port 0 highest.
module mssd_tx_arbiter
    import mssd_tx_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PN_W-1:0]      ptr,
    output logic [NUM_PORTS-1:0] winner
);

    pn_t  start;
    pn_t  idx;
    logic found;

`ifdef MSSD_TX_RR_EN
    assign start = ptr;
`else
    // Fixed priority is a rotating search that always starts at port 0.
    logic ptr_unused;
    assign ptr_unused = ^ptr;
    assign start      = '0;
`endif

    // Walk the ports from start upward (wrapping) and grant the first requester.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        idx    = start;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = start + pn_t'(i);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mssd_tx_scheduler.sv
// mssd_tx_scheduler -- serialises frames from four ports onto one line.
// Frame: start bit, 2-bit port number, 6-bit length (LSB first), len payload
// bytes (LSB first), stop bit. SerOut is registered and loaded together with
// the state, so it always shows the bit of the state being entered.
// Macro MSSD_TX_RR_EN selects round-robin arbitration (see mssd_tx_arbiter).
module mssd_tx_scheduler
    import mssd_tx_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0][LEN_W-1:0]  len,
    input  logic [7:0]                       data_in,
    input  logic                             data_valid,
    output logic                             data_ready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic [NUM_PORTS-1:0]             done,
    output logic                             SerOut,
    output logic                             underrun,
    output logic                             len_err
);

    state_t               state_q, state_d;
    pn_t                  pn_q, pn_d;
    len_t                 len_q, len_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    len_t                 byte_cnt_q, byte_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 ser_q, ser_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic                 underrun_q, underrun_d;
    logic                 len_err_q, len_err_d;
    pn_t                  rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0] winner;
    pn_t                  win_pn;
    logic [7:0]           fetch_byte;

    mssd_tx_arbiter u_arbiter (
        .req    (req),
        .ptr    (rr_ptr_q),
        .winner (winner)
    );

    assign win_pn     = onehot_to_pn(winner);
    // A missing byte is replaced by zero so the frame keeps its length.
    assign fetch_byte = data_valid ? data_in : 8'h00;

    assign SerOut   = ser_q;
    assign grant    = grant_q;
    assign done     = done_q;
    assign underrun = underrun_q;
    assign len_err  = len_err_q;

    // Next-state, next line bit and strobes for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        pn_d       = pn_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        ser_d      = STOP_BIT;
        grant_d    = grant_q;
        done_d     = '0;
        underrun_d = 1'b0;
        len_err_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        data_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A port whose done is still showing is not re-arbitrated yet.
                if ((req & ~done_q) != '0) state_d = ARB;
            end

            ARB: begin
                if (winner != '0) begin
                    pn_d     = win_pn;
                    len_d    = len[win_pn];
                    rr_ptr_d = win_pn + pn_t'(1);
                    if (len[win_pn] == '0) begin
                        len_err_d = 1'b1;
                        done_d    = winner;
                        state_d   = IDLE;
                    end else begin
                        grant_d = winner;
                        shift_d = {len[win_pn], win_pn};
                        ser_d   = START_BIT;
                        state_d = START;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                ser_d     = shift_q[0];
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = '0;
                state_d   = HEADER;
            end

            HEADER: begin
                if (bit_cnt_q == LAST_BIT) begin
                    data_ready = 1'b1;
                    underrun_d = ~data_valid;
                    ser_d      = fetch_byte[0];
                    shift_d    = {1'b0, fetch_byte[7:1]};
                    bit_cnt_d  = '0;
                    byte_cnt_d = len_t'(1);
                    state_d    = DATA;
                end else begin
                    ser_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end

            DATA: begin
                if (bit_cnt_q != LAST_BIT) begin
                    ser_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else if (byte_cnt_q == len_q) begin
                    ser_d   = STOP_BIT;
                    done_d  = grant_q;
                    state_d = STOP;
                end else begin
                    data_ready = 1'b1;
                    underrun_d = ~data_valid;
                    ser_d      = fetch_byte[0];
                    shift_d    = {1'b0, fetch_byte[7:1]};
                    bit_cnt_d  = '0;
                    byte_cnt_d = byte_cnt_q + len_t'(1);
                end
            end

            STOP: begin
                grant_d = '0;
                state_d = IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pn_q       <= '0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            ser_q      <= STOP_BIT;
            grant_q    <= '0;
            done_q     <= '0;
            underrun_q <= 1'b0;
            len_err_q  <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            pn_q       <= pn_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            ser_q      <= ser_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            len_err_q  <= len_err_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: doc/mssd_tx_scheduler.md
MSSD_TX_SCHEDULER -- requirements
Module: mssd_tx_scheduler

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-003 SHALL expose: req  input  4  per-port frame request, level, held until that port's done.
REQ-004 SHALL expose: len  input  4x6  per-port payload length in bytes, sampled at grant.
REQ-005 SHALL expose: data_in  input  8  payload byte from the granted port.
REQ-006 SHALL expose: data_valid  input  1  data_in is valid.
REQ-007 SHALL expose: data_ready  output  1  one-cycle byte-fetch strobe to the granted port.
REQ-008 SHALL expose: grant  output  4  one-hot owner of the line, all zero when idle.
REQ-009 SHALL expose: done  output  4  one-cycle completion pulse to the owning port.
REQ-010 SHALL expose: SerOut  output  1  serial line, registered, idle high.
REQ-011 SHALL expose: underrun  output  1  one-cycle pulse, byte missing at fetch.
REQ-012 SHALL expose: len_err  output  1  one-cycle pulse, request with len==0 dropped.

Function
REQ-013 SHALL use states IDLE, ARB, START, HEADER, DATA and STOP.
REQ-014 IDLE: SerOut=1 and grant=0; move to ARB when any req bit is 1.
REQ-015 ARB, one cycle: select the winner, latch its port number and len, and drive grant from the next cycle.
REQ-016 If the winner's len==0, SHALL pulse len_err and done[winner], send no frame, and return to IDLE.
REQ-017 START: SerOut=0 for one cycle.
REQ-018 HEADER: 8 cycles that send pn[0], pn[1], then len[0] through len[5], LSB first.
REQ-019 DATA: exactly 8*len cycles; each byte goes out LSB first; the byte counter is 6 bits and terminates on the last bit of byte len.
REQ-020 STOP: SerOut=1 for one cycle, done[owner] pulses, grant clears on the next cycle, then the block returns to IDLE.
REQ-021 There SHALL be at least one IDLE cycle (SerOut=1) between consecutive frames.
REQ-022 data_ready SHALL pulse in the last HEADER cycle and in bit 7 of each DATA byte except the last.
REQ-023 On a data_ready cycle, if data_valid=1 the block SHALL capture data_in; otherwise it SHALL capture 0x00 and pulse underrun in the next cycle. The frame never stalls.
REQ-024 Changes to req, len or port in mid-frame SHALL be ignored; the latched values govern the frame.
REQ-025 Latency from req rising in IDLE to the start bit on SerOut SHALL be 2 cycles.

Reset
REQ-026 rst=0 SHALL force IDLE, SerOut=1, and grant, done, data_ready, underrun and len_err all 0, with the round-robin pointer at port 0, immediately (asynchronous), including in mid-frame.
REQ-027 A frame aborted by reset SHALL not be resumed, and its done SHALL not be issued.

Configuration
REQ-028 With macro MSSD_TX_RR_EN defined, arbitration SHALL be round-robin: search starts at the port after the last winner, and the pointer updates in ARB.
REQ-029 Without MSSD_TX_RR_EN, arbitration SHALL be fixed priority: port 0 highest, port 3 lowest.

Structure
REQ-030 A shared package SHALL hold the state enum, the port-number typedef (2 bit), the length typedef (6 bit), START_BIT=0, STOP_BIT=1 and HDR_BITS=8.
REQ-031 The arbiter SHALL be a separate sub-module, mssd_tx_arbiter (req, pointer -> one-hot winner), containing the MSSD_TX_RR_EN selection.

Verification
REQ-032 Port 2, len=1, data 0xA5 valid -> SerOut 0,0,1,1,0,0,0,0,0,1,0,1,0,0,1,0,1,1; done[2] pulses in the STOP cycle; total frame 18 cycles.
REQ-033 req=4'b1111 held, len=1 each, MSSD_TX_RR_EN on -> grant order 0,1,2,3,0; without the macro -> 0,0,0.
REQ-034 Port 1, len=3, data_valid low at the second fetch -> second byte sent as 0x00, one underrun pulse, frame length unchanged (9+24+1 cycles).
REQ-035 Port 3, len=0 -> len_err and done[3] pulse, SerOut stays 1, next request is served normally.
REQ-036 rst driven low in DATA bit 5 -> SerOut=1 and grant=0 in the same cycle, no done; after release, a fresh req produces a complete frame.
REQ-037 Loopback into the existing serial receiver with len=63 -> receiver outValid for 504 cycles, error never asserted.
